// File: rtl/gf_mul_pkg.sv
// rtl/gf_mul_pkg.sv - shared types, constants and helpers for the digit-serial GF(2^n) multiplier
// State encoding, default GCM reduction polynomial and a clog2 helper for counter sizing.
package gf_mul_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    COMP = 1'b1
  } state_t;

  localparam logic [127:0] GF128_POLY = 128'h87;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/gf_mulx_step.sv
// rtl/gf_mulx_step.sv - one bit step of the interleaved multiply: conditional accumulate and multiply-by-x
// Purely combinational; the top chains DIGIT copies to consume DIGIT bits of H per cycle.
module gf_mulx_step
  import gf_mul_pkg::*;
#(
  parameter int               WIDTH = 128,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(GF128_POLY)
) (
  input  logic [WIDTH-1:0] z,
  input  logic [WIDTH-1:0] v,
  input  logic             h_bit,
  output logic [WIDTH-1:0] z_next,
  output logic [WIDTH-1:0] v_next
);

  assign z_next = h_bit ? (z ^ v) : z;
  // x^WIDTH folds back in as POLY when the top coefficient shifts out
  assign v_next = v[WIDTH-1] ? ((v << 1) ^ POLY) : (v << 1);

endmodule

// File: rtl/gf_mul_digit.sv
// rtl/gf_mul_digit.sv - digit-serial GF(2^WIDTH) multiplier with optional GHASH-style accumulate
// Consumes DIGIT bits of H per cycle, LSB first; result lands in R after WIDTH/DIGIT compute cycles.
module gf_mul_digit
  import gf_mul_pkg::*;
#(
  parameter int               WIDTH = 128,
  parameter int               DIGIT = 1,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(GF128_POLY)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic             acc_clr,
  input  logic [WIDTH-1:0] H,
  input  logic [WIDTH-1:0] block_i,
  output logic [WIDTH-1:0] result_o,
  output logic             busy,
  output logic             done
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = clog2(N) + 1;

  if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
    $error("gf_mul_digit: DIGIT must divide WIDTH");
  end

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] z_q;
  logic [WIDTH-1:0] v_q;
  logic [WIDTH-1:0] h_q;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] op;
  logic             last;

  logic [WIDTH-1:0] z_c [DIGIT+1];
  logic [WIDTH-1:0] v_c [DIGIT+1];

  assign z_c[0] = z_q;
  assign v_c[0] = v_q;

  // h_q is shifted right by DIGIT each cycle, so bit j is always H[cnt*DIGIT+j]
  for (genvar j = 0; j < DIGIT; j++) begin : g_step
    gf_mulx_step #(
      .WIDTH (WIDTH),
      .POLY  (POLY)
    ) u_step (
      .z      (z_c[j]),
      .v      (v_c[j]),
      .h_bit  (h_q[j]),
      .z_next (z_c[j+1]),
      .v_next (v_c[j+1])
    );
  end

  assign op       = (mode && !acc_clr) ? (block_i ^ r_q) : block_i;
  assign last     = (cnt == CW'(N - 1));
  assign result_o = r_q;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = COMP;
      COMP:    if (last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      r_q   <= '0;
      z_q   <= '0;
      v_q   <= '0;
      h_q   <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            v_q  <= op;
            z_q  <= '0;
            h_q  <= H;
            cnt  <= '0;
            busy <= 1'b1;
          end
          if (acc_clr) r_q <= '0;
        end
        COMP: begin
          z_q <= z_c[DIGIT];
          v_q <= v_c[DIGIT];
          h_q <= h_q >> DIGIT;
          cnt <= cnt + CW'(1);
          if (last) begin
            r_q  <= z_c[DIGIT];
            done <= 1'b1;
            busy <= 1'b0;
            cnt  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gf_mul_digit.sv
// tb/tb_gf_mul_digit.sv - self-checking bench for gf_mul_digit across DIGIT=1..16 and the AES field
module tb_gf_mul_digit;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         mode = 1'b0;
  logic         acc_clr = 1'b0;
  logic [127:0] h = '0;
  logic [127:0] blk = '0;
  logic [127:0] res [5];
  logic         bsy [5];
  logic         dn  [5];

  logic         a_start = 1'b0;
  logic         a_mode = 1'b0;
  logic         a_clr = 1'b0;
  logic [7:0]   a_h = '0;
  logic [7:0]   a_b = '0;
  logic [7:0]   a_res;
  logic         a_busy;
  logic         a_done;

  int           n_assert = 0;
  int           n_fail = 0;
  logic [127:0] model_r = '0;
  logic [7:0]   a_model_r = '0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 5; g++) begin : g_dut
    gf_mul_digit #(
      .WIDTH (128),
      .DIGIT (1 << g),
      .POLY  (128'h87)
    ) u_dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .mode     (mode),
      .acc_clr  (acc_clr),
      .H        (h),
      .block_i  (blk),
      .result_o (res[g]),
      .busy     (bsy[g]),
      .done     (dn[g])
    );
  end

  gf_mul_digit #(
    .WIDTH (8),
    .DIGIT (2),
    .POLY  (8'h1B)
  ) u_aes (
    .clk      (clk),
    .reset    (reset),
    .start    (a_start),
    .mode     (a_mode),
    .acc_clr  (a_clr),
    .H        (a_h),
    .block_i  (a_b),
    .result_o (a_res),
    .busy     (a_busy),
    .done     (a_done)
  );

  // Reference: full carry-less product, then reduce top-down using x^128 = 0x87
  function automatic logic [127:0] ref_mul(input logic [127:0] a, input logic [127:0] b);
    logic [255:0] p;
    p = '0;
    for (int i = 0; i < 128; i++) if (b[i]) p ^= ({128'b0, a} << i);
    for (int i = 255; i >= 128; i--) if (p[i]) p ^= (256'h87 << (i - 128)) ^ (256'b1 << i);
    return p[127:0];
  endfunction

  function automatic logic [7:0] ref_mul8(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p ^= ({8'b0, a} << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p ^= (16'h1B << (i - 8)) ^ (16'b1 << i);
    return p[7:0];
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One multiply on all five 128-bit instances; poke>0 injects start+acc_clr while busy
  task automatic run_op(input logic [127:0] hv, input logic [127:0] bv, input logic m,
                        input logic c, input string tag, input int poke);
    bit           seen [5];
    int           lat [5];
    logic [127:0] prev_r;
    logic [127:0] op;
    prev_r  = model_r;
    op      = (m && !c) ? (bv ^ model_r) : bv;
    model_r = ref_mul(op, hv);
    @(negedge clk);
    h = hv; blk = bv; mode = m; acc_clr = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0; acc_clr = 1'b0; mode = 1'($urandom);
    chk({tag, "_busy"}, 128'(bsy[0]), 128'd1);
    for (int k = 1; k <= 140 && !seen[0]; k++) begin
      if (k == poke) begin
        chk({tag, "_hold"}, res[0], c ? 128'd0 : prev_r);
        start = 1'b1; acc_clr = 1'b1; h = ~hv; blk = {$urandom, $urandom, $urandom, $urandom};
      end
      @(negedge clk);
      start = 1'b0; acc_clr = 1'b0;
      for (int g = 0; g < 5; g++) begin
        if (seen[g] && lat[g] == k) chk({tag, "_pulse"}, 128'(dn[g]), 128'd0);
        if (dn[g] && !seen[g]) begin
          seen[g] = 1'b1;
          lat[g]  = k + 1;
          chk({tag, "_res"}, res[g], model_r);
        end
      end
    end
    for (int g = 0; g < 5; g++) chk({tag, "_lat"}, 128'(lat[g]), 128'((128 >> g) + 1));
  endtask

  task automatic aes_op(input logic [7:0] hv, input logic [7:0] bv);
    int lat;
    lat = 0;
    a_model_r = ref_mul8(bv, hv);
    @(negedge clk);
    a_h = hv; a_b = bv; a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      @(negedge clk);
      if (a_done) begin
        lat = k + 1;
        chk("aes_res", 128'(a_res), 128'(a_model_r));
      end
    end
    chk("aes_lat", 128'(lat), 128'd5);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int g = 0; g < 5; g++) begin
      chk("rst_res", res[g], 128'd0);
      chk("rst_busy", 128'(bsy[g]), 128'd0);
      chk("rst_done", 128'(dn[g]), 128'd0);
    end

    run_op(128'd1, 128'hDEADBEEF, 1'b0, 1'b0, "ident", -1);
    run_op(128'd2, {1'b1, 127'b0}, 1'b0, 1'b0, "reduce", -1);

    for (int i = 0; i < 200; i++)
      run_op({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
             1'b0, 1'b0, "rand", -1);

    // Accumulate chain: clear, then 1 -> 2, 0 -> 4, 4 -> 0, clr+3 -> 6
    @(negedge clk); acc_clr = 1'b1;
    @(negedge clk); acc_clr = 1'b0; model_r = '0;
    for (int g = 0; g < 5; g++) chk("clr_res", res[g], 128'd0);
    run_op(128'd2, 128'd1, 1'b1, 1'b0, "acc1", -1);
    run_op(128'd2, 128'd0, 1'b1, 1'b0, "acc2", -1);
    run_op(128'd2, 128'd4, 1'b1, 1'b0, "acc3", -1);
    run_op(128'd2, 128'd3, 1'b1, 1'b1, "acc4", -1);

    // start and acc_clr while busy must be ignored
    run_op({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
           1'b1, 1'b0, "busy_ign", 3);

    // Continuous start: one product every N+1 cycles
    begin
      int t1 [5];
      int t2 [5];
      logic [127:0] hv, bv;
      hv = {$urandom, $urandom, $urandom, $urandom};
      bv = {$urandom, $urandom, $urandom, $urandom};
      model_r = ref_mul(bv, hv);
      for (int g = 0; g < 5; g++) begin t1[g] = 0; t2[g] = 0; end
      @(negedge clk);
      h = hv; blk = bv; mode = 1'b0; start = 1'b1;
      for (int k = 1; k <= 262; k++) begin
        @(negedge clk);
        for (int g = 0; g < 5; g++) if (dn[g]) begin
          if (t1[g] == 0) t1[g] = k;
          else if (t2[g] == 0) t2[g] = k;
          chk("cont_res", res[g], model_r);
        end
      end
      start = 1'b0;
      for (int g = 0; g < 5; g++) chk("cont_period", 128'(t2[g] - t1[g]), 128'((128 >> g) + 1));
      for (int k = 0; k < 200 && bsy[0]; k++) @(negedge clk);
      @(negedge clk);
      for (int g = 0; g < 5; g++) chk("cont_idle", 128'(bsy[g]), 128'd0);
    end

    // Reset at cycle 50 of an operation
    begin
      bit saw_done;
      saw_done = 1'b0;
      @(negedge clk);
      h = {$urandom, $urandom, $urandom, $urandom}; blk = 128'd5; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (49) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      model_r = '0;
      for (int k = 0; k < 150; k++) begin
        @(negedge clk);
        if (dn[0] || bsy[0]) saw_done = 1'b1;
      end
      chk("rstmid_quiet", 128'(saw_done), 128'd0);
      for (int g = 0; g < 5; g++) chk("rstmid_res", res[g], 128'd0);
      run_op({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
             1'b0, 1'b0, "after_rst", -1);
    end

    aes_op(8'h57, 8'h83);
    chk("aes_c1", 128'(a_res), 128'hC1);
    for (int i = 0; i < 20; i++) aes_op(8'($urandom), 8'($urandom));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
